// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART on the core data port: 16-byte register window,
// zero-latency loads, TX FIFO into a serializer, deserializer into an RX FIFO.
module mmio_uart #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] din,
  output logic [31:0] read_data,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] DEPTH    = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_e;

  logic       hit;
  logic [1:0] sel;
  logic       wr_tx, wr_rx, wr_st;

  assign hit   = data_addr[31:4] == IO_BASE[31:4];
  assign sel   = data_addr[3:2];
  assign wr_tx = data_we & hit & (sel == 2'd0);
  assign wr_rx = data_we & hit & (sel == 2'd1);
  assign wr_st = data_we & hit & (sel == 2'd2);

  logic unused_ok;
  assign unused_ok = ^{din[31:8], data_addr[1:0]};

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q, tx_lvl;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;

  tx_state_e     tx_st_q;
  logic [CW-1:0] tx_baud_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          txd_q;

  assign tx_lvl   = tx_wp_q - tx_rp_q;
  assign tx_full  = tx_lvl == DEPTH;
  assign tx_empty = tx_lvl == '0;
  assign tx_push  = wr_tx & ~tx_full;
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
  assign tx_pop   = ~tx_empty &
                    ((tx_st_q == TX_IDLE) |
                     ((tx_st_q == TX_STOP) & (tx_baud_q == BIT_END)));
  assign uart_txd = txd_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= din[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q   <= TX_IDLE;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      unique case (tx_st_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_st_q   <= TX_START;
            tx_sh_q   <= tx_head;
            tx_baud_q <= '0;
            txd_q     <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_baud_q == BIT_END) begin
            tx_baud_q <= '0;
            tx_bit_q  <= '0;
            tx_st_q   <= TX_DATA;
            txd_q     <= tx_sh_q[0];
          end else begin
            tx_baud_q <= tx_baud_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_baud_q == BIT_END) begin
            tx_baud_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= TX_STOP;
              txd_q   <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              txd_q    <= tx_sh_q[1];
            end
          end else begin
            tx_baud_q <= tx_baud_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_baud_q == BIT_END) begin
            tx_baud_q <= '0;
            // Chain straight into the next start bit: no idle gap.
            if (tx_pop) begin
              tx_st_q <= TX_START;
              tx_sh_q <= tx_head;
              txd_q   <= 1'b0;
            end else begin
              tx_st_q <= TX_IDLE;
            end
          end else begin
            tx_baud_q <= tx_baud_q + CW'(1);
          end
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  logic rx_s1_q, rx_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rxd;
      rx_s2_q <= rx_s1_q;
    end
  end

  rx_state_e     rx_st_q;
  logic [CW-1:0] rx_baud_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_done, rx_push, fe_set;

  assign rx_done = (rx_st_q == RX_STOP) & (rx_baud_q == BIT_END);
  assign rx_push = rx_done & rx_s2_q;
  assign fe_set  = rx_done & ~rx_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st_q   <= RX_IDLE;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      unique case (rx_st_q)
        RX_IDLE: begin
          rx_baud_q <= '0;
          if (!rx_s2_q) rx_st_q <= RX_START;
        end
        RX_START: begin
          if (rx_baud_q == HALF_END) begin
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            rx_st_q   <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud_q <= rx_baud_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_baud_q == BIT_END) begin
            rx_baud_q <= '0;
            rx_sh_q   <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q  <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            rx_baud_q <= rx_baud_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_baud_q == BIT_END) begin
            rx_baud_q <= '0;
            rx_st_q   <= rx_s2_q ? RX_IDLE : RX_WAIT;
          end else begin
            rx_baud_q <= rx_baud_q + CW'(1);
          end
        end
        RX_WAIT: begin
          if (rx_s2_q) rx_st_q <= RX_IDLE;
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp_q, rx_rp_q, rx_lvl;
  logic          rx_full, rx_empty, rx_pop, rx_wr;
  logic [7:0]    rx_head;

  assign rx_lvl   = rx_wp_q - rx_rp_q;
  assign rx_full  = rx_lvl == DEPTH;
  assign rx_empty = rx_lvl == '0;
  assign rx_pop   = wr_rx & ~rx_empty;
  assign rx_wr    = rx_push & (~rx_full | rx_pop);
  assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (rx_wr)  rx_wp_q <= rx_wp_q + PW'(1);
      if (rx_pop) rx_rp_q <= rx_rp_q + PW'(1);
    end
  end

  logic rx_ovf_q, fe_q, tx_ovf_q;
  logic rx_ovf_d, fe_d, tx_ovf_d;

  // A set in the same cycle as a software clear takes priority.
  assign rx_ovf_d = (rx_push & ~rx_wr) | (rx_ovf_q & ~(wr_st & din[3]));
  assign fe_d     = fe_set | (fe_q & ~(wr_st & din[4]));
  assign tx_ovf_d = (wr_tx & tx_full) | (tx_ovf_q & ~(wr_st & din[5]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ovf_q <= 1'b0;
      fe_q     <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      fe_q     <= fe_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  logic [31:0] status;
  assign status = {26'b0, tx_ovf_q, fe_q, rx_ovf_q,
                   tx_empty & (tx_st_q == TX_IDLE),
                   tx_full, ~rx_empty};

  always_comb begin
    read_data = '0;
    if (hit) begin
      unique case (sel)
        2'd0: read_data = '0;
        2'd1: read_data = rx_empty ? 32'b0 : {24'b0, rx_head};
        2'd2: read_data = status;
        2'd3: read_data = {{(32-PW){1'b0}}, rx_lvl};
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed/randomized bench for mmio_uart with a queue-based reference
// model of the register file, both FIFOs and the 8N1 line format.
module tb_mmio_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_CN = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] din = '0;
  logic [31:0] read_data;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  byte unsigned rxq[$];
  bit m_rxovf = 0;
  bit m_fe    = 0;
  bit m_txovf = 0;

  always #5 clk = ~clk;

  mmio_uart #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .IO_BASE(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_we(data_we),
    .data_addr(data_addr),
    .din(din),
    .read_data(read_data),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    data_addr = a;
    #1;
    v = read_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    data_addr = a;
    din       = d;
    data_we   = 1'b1;
    @(posedge clk);
    #1;
    data_we = 1'b0;
  endtask

  function automatic logic [FLEN-1:0] tx_wave(input logic [7:0] b);
    logic [9:0]      f;
    logic [FLEN-1:0] w;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++)
        w[i*CPB+j] = f[i];
    return w;
  endfunction

  function automatic logic [31:0] exp_status(input bit idle);
    logic [31:0] s;
    s    = '0;
    s[0] = rxq.size() != 0;
    s[2] = idle;
    s[3] = m_rxovf;
    s[4] = m_fe;
    s[5] = m_txovf;
    return s;
  endfunction

  task automatic m_push(input byte unsigned b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_rxovf = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    logic [31:0]     v;
    logic [FLEN-1:0] cap1;
    logic [5*FLEN:0] cap5;
    logic [7:0]      tb_b [6];
    logic [7:0]      b;

    // Reset values
    #12;
    chk("rst_txd", 64'(uart_txd), 64'h1);
    rd(A_ST, v); chk("rst_status", 64'(v), 64'h4);
    rd(A_CN, v); chk("rst_rxcount", 64'(v), 64'h0);
    rd(A_RX, v); chk("rst_rxdata", 64'(v), 64'h0);
    rd(A_TX, v); chk("rst_txdata", 64'(v), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single TX frames: fixed 0xA5 then a random byte
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      wr(A_TX, {24'b0, b});
      for (int i = 0; i < FLEN; i++) begin
        @(posedge clk);
        #1;
        cap1[i] = uart_txd;
        if (i == 20) begin
          rd(A_ST, v);
          chk("tx_busy_status", 64'(v), 64'(exp_status(0)));
        end
      end
      chk("tx_frame", 64'(cap1), 64'(tx_wave(b)));
      @(posedge clk);
      #1;
      rd(A_ST, v); chk("tx_idle_after", 64'(v), 64'(exp_status(1)));
    end

    // Reset in the middle of a frame of zeros
    wr(A_TX, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_txd_low", 64'(uart_txd), 64'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_txd", 64'(uart_txd), 64'h1);
    rd(A_ST, v); chk("mid_rst_status", 64'(v), 64'h4);
    rd(A_CN, v); chk("mid_rst_rxcount", 64'(v), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // TX overflow: six back-to-back stores, five frames leave the wire
    for (int i = 0; i < 6; i++) tb_b[i] = 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) wr(A_TX, {24'b0, tb_b[i]});
      end
      begin
        @(posedge clk);
        for (int i = 0; i <= 5 * FLEN; i++) begin
          @(posedge clk);
          #1;
          cap5[i] = uart_txd;
        end
      end
    join
    m_txovf = 1'b1;
    for (int f = 0; f < DEPTH + 1; f++)
      chk("tx_ovf_frame", 64'(cap5[f*FLEN +: FLEN]), 64'(tx_wave(tb_b[f])));
    chk("tx_ovf_tail_idle", 64'(cap5[5*FLEN]), 64'h1);
    rd(A_ST, v); chk("tx_ovf_status", 64'(v), 64'(exp_status(1)));
    wr(A_ST, 32'h20);
    m_txovf = 1'b0;
    rd(A_ST, v); chk("tx_ovf_clear", 64'(v), 64'(exp_status(1)));

    // Single RX byte
    send_rx(8'h3C, 1'b1);
    m_push(8'h3C);
    rd(A_CN, v); chk("rx_count1", 64'(v), 64'(rxq.size()));
    rd(A_RX, v); chk("rx_data1", 64'(v), 64'(rxq[0]));
    wr(A_RX, 32'($urandom));
    void'(rxq.pop_front());
    rd(A_CN, v); chk("rx_count_pop", 64'(v), 64'h0);
    rd(A_RX, v); chk("rx_data_empty", 64'(v), 64'h0);

    // RX fill past capacity
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      send_rx(b, 1'b1);
      m_push(b);
    end
    rd(A_CN, v); chk("rx_full_count", 64'(v), 64'(rxq.size()));
    rd(A_ST, v); chk("rx_full_status", 64'(v), 64'(exp_status(1)));
    rd(A_RX, v); chk("rx_full_head", 64'(v), 64'(rxq[0]));
    wr(A_ST, 32'h08);
    m_rxovf = 1'b0;
    rd(A_ST, v); chk("rx_ovf_clear", 64'(v), 64'(exp_status(1)));

    // Pop on the very edge a byte arrives into the full FIFO
    b = 8'($urandom_range(0, 255));
    fork
      send_rx(b, 1'b1);
      begin
        @(negedge clk);
        repeat (FLEN) @(negedge clk);
        data_addr = A_RX;
        data_we   = 1'b1;
        @(posedge clk);
        #1;
        data_we = 1'b0;
      end
    join
    void'(rxq.pop_front());
    m_push(b);
    rd(A_CN, v); chk("rx_simul_count", 64'(v), 64'(rxq.size()));
    rd(A_ST, v); chk("rx_simul_status", 64'(v), 64'(exp_status(1)));
    while (rxq.size() != 0) begin
      rd(A_RX, v); chk("rx_drain", 64'(v), 64'(rxq[0]));
      wr(A_RX, 32'h0);
      void'(rxq.pop_front());
    end
    rd(A_CN, v); chk("rx_drained", 64'(v), 64'h0);

    // One-cycle glitch is rejected
    @(negedge clk);
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    rd(A_CN, v); chk("rx_glitch", 64'(v), 64'h0);

    // Framing error, then a clean frame
    send_rx(8'($urandom_range(0, 255)), 1'b0);
    m_fe = 1'b1;
    rd(A_ST, v); chk("rx_fe_status", 64'(v), 64'(exp_status(1)));
    rd(A_CN, v); chk("rx_fe_count", 64'(v), 64'(rxq.size()));
    b = 8'($urandom_range(0, 255));
    send_rx(b, 1'b1);
    m_push(b);
    rd(A_CN, v); chk("rx_after_fe_count", 64'(v), 64'(rxq.size()));
    rd(A_RX, v); chk("rx_after_fe_data", 64'(v), 64'(rxq[0]));
    wr(A_ST, 32'h10);
    m_fe = 1'b0;
    rd(A_ST, v); chk("rx_fe_clear", 64'(v), 64'(exp_status(1)));

    // Stores ignored: RXCOUNT and out-of-window aliases
    wr(A_CN, 32'hFFFF_FFFF);
    wr(32'hFFFF_FE04, 32'h0);
    wr(BASE + 32'h10, 32'h55);
    rd(A_CN, v); chk("ignored_stores_count", 64'(v), 64'(rxq.size()));
    rd(A_ST, v); chk("ignored_stores_status", 64'(v), 64'(exp_status(1)));
    rd(32'hFFFF_FE04, v); chk("miss_bit8", 64'(v), 64'h0);
    rd(BASE + 32'h14, v); chk("miss_bit4", 64'(v), 64'h0);
    rd(32'h0000_0008, v); chk("miss_low", 64'(v), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
